// File: rtl/agu_issue_arbiter.sv
// ============================================================================
// agu_issue_arbiter : oldest-first load/store arbiter feeding the AGU issue slot
// Revision 1.0
// ============================================================================
`default_nettype none

module agu_issue_arbiter #(
  parameter int ROB_TAG_W    = 6,
  parameter int PAYLOAD_W    = 96,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid_i,
  input  logic [ROB_TAG_W-1:0] ld_tag_i,
  input  logic                 ld_ni_i,
  input  logic [PAYLOAD_W-1:0] ld_payload_i,
  output logic                 ld_grant_o,
  input  logic                 st_valid_i,
  input  logic [ROB_TAG_W-1:0] st_tag_i,
  input  logic                 st_ni_i,
  input  logic [PAYLOAD_W-1:0] st_payload_i,
  output logic                 st_grant_o,
  input  logic                 stall_i,
  input  logic                 flush_valid_i,
  input  logic [ROB_TAG_W-1:0] flush_tag_i,
  input  logic                 replay_cancel_i,
  input  logic                 ni_done_i,
  output logic                 issue_valid_o,
  output logic                 issue_is_store_o,
  output logic [ROB_TAG_W-1:0] issue_tag_o,
  output logic [PAYLOAD_W-1:0] issue_payload_o,
  output logic                 ni_busy_o
);

  localparam int                 c_cnt_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    NI_WAIT = 1'b1
  } state_e;

  // Wrap-bit age compare; equal tags are never "older".
  function automatic logic older(input logic [ROB_TAG_W-1:0] a,
                                 input logic [ROB_TAG_W-1:0] b);
    if (a[ROB_TAG_W-1] == b[ROB_TAG_W-1])
      return a[ROB_TAG_W-2:0] < b[ROB_TAG_W-2:0];
    else
      return a[ROB_TAG_W-2:0] > b[ROB_TAG_W-2:0];
  endfunction

  state_e               state_q;
  logic [ROB_TAG_W-1:0] ni_tag_q;
  logic                 ni_busy_q;
  logic [c_cnt_w-1:0]   ld_cnt_q, ld_cnt_d;
  logic [c_cnt_w-1:0]   st_cnt_q, st_cnt_d;
  logic                 issue_valid_q, issue_valid_d;
  logic                 issue_is_store_q, issue_is_store_d;
  logic [ROB_TAG_W-1:0] issue_tag_q, issue_tag_d;
  logic [PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;

  logic w_ld_killed, w_st_killed, w_slot_killed, w_ni_killed;
  logic w_gate, w_ld_elig, w_st_elig, w_pick_store, w_gnt_any, w_gnt_ni;
  logic [ROB_TAG_W-1:0] w_gnt_tag;

  assign w_ld_killed   = flush_valid_i && older(flush_tag_i, ld_tag_i);
  assign w_st_killed   = flush_valid_i && older(flush_tag_i, st_tag_i);
  assign w_slot_killed = flush_valid_i && older(flush_tag_i, issue_tag_q);
  assign w_ni_killed   = flush_valid_i && older(flush_tag_i, ni_tag_q);

  assign w_gate    = !stall_i && !replay_cancel_i && (state_q == IDLE);
  assign w_ld_elig = ld_valid_i && !w_ld_killed && w_gate;
  assign w_st_elig = st_valid_i && !w_st_killed && w_gate;

  // Starved requester overrides age; age ties go to the load.
  always_comb begin
    w_pick_store = w_st_elig;
    if (w_ld_elig && w_st_elig) begin
      if (ld_cnt_q == c_limit)      w_pick_store = 1'b0;
      else if (st_cnt_q == c_limit) w_pick_store = 1'b1;
      else                          w_pick_store = older(st_tag_i, ld_tag_i);
    end
  end

  assign ld_grant_o = w_ld_elig && !w_pick_store;
  assign st_grant_o = w_st_elig && w_pick_store;
  assign w_gnt_any  = ld_grant_o || st_grant_o;
  assign w_gnt_ni   = st_grant_o ? st_ni_i  : ld_ni_i;
  assign w_gnt_tag  = st_grant_o ? st_tag_i : ld_tag_i;

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (state_q == IDLE) begin
      if (!ld_valid_i || ld_grant_o)              ld_cnt_d = '0;
      else if (w_ld_elig && ld_cnt_q != c_limit)  ld_cnt_d = ld_cnt_q + c_one;
      if (!st_valid_i || st_grant_o)              st_cnt_d = '0;
      else if (w_st_elig && st_cnt_q != c_limit)  st_cnt_d = st_cnt_q + c_one;
    end
  end

  always_comb begin
    issue_valid_d    = issue_valid_q;
    issue_is_store_d = issue_is_store_q;
    issue_tag_d      = issue_tag_q;
    issue_payload_d  = issue_payload_q;
    if (stall_i) begin
      if (w_slot_killed) issue_valid_d = 1'b0;
    end else if (replay_cancel_i) begin
      issue_valid_d    = 1'b0;
      issue_is_store_d = 1'b0;
      issue_tag_d      = '0;
      issue_payload_d  = '0;
    end else if (w_gnt_any) begin
      issue_valid_d    = 1'b1;
      issue_is_store_d = st_grant_o;
      issue_tag_d      = w_gnt_tag;
      issue_payload_d  = st_grant_o ? st_payload_i : ld_payload_i;
    end else begin
      issue_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ni_tag_q  <= '0;
      ni_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_gnt_any && w_gnt_ni) begin
            state_q   <= NI_WAIT;
            ni_tag_q  <= w_gnt_tag;
            ni_busy_q <= 1'b1;
          end
        end
        NI_WAIT: begin
          if (ni_done_i || w_ni_killed) begin
            state_q   <= IDLE;
            ni_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          ni_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q         <= '0;
      st_cnt_q         <= '0;
      issue_valid_q    <= 1'b0;
      issue_is_store_q <= 1'b0;
      issue_tag_q      <= '0;
      issue_payload_q  <= '0;
    end else begin
      ld_cnt_q         <= ld_cnt_d;
      st_cnt_q         <= st_cnt_d;
      issue_valid_q    <= issue_valid_d;
      issue_is_store_q <= issue_is_store_d;
      issue_tag_q      <= issue_tag_d;
      issue_payload_q  <= issue_payload_d;
    end
  end

  assign issue_valid_o    = issue_valid_q;
  assign issue_is_store_o = issue_is_store_q;
  assign issue_tag_o      = issue_tag_q;
  assign issue_payload_o  = issue_payload_q;
  assign ni_busy_o        = ni_busy_q;

endmodule

`default_nettype wire
